bus_xbar_reg: RTL and testbench

// - Registered, parametrised master/slave crossbar for the serial bus; the successor to the combinational interconnect.
// - Accepts a connection request {master_id, slave_id} from the arbiter through a valid/ack handshake and holds that

---
 rtl/bus_xbar_reg.sv | 158 +++++++++++++++
 tb/tb_bus_xbar_reg.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bus_xbar_reg.sv
// bus_xbar_reg: registered master/slave crossbar holding one connection from arbiter request until last beat or watchdog abort.
// Define BUS_XBAR_PIPE_EN to register the forward and return data paths once.
module bus_xbar_reg #(
    parameter int NO_MASTERS = 2,
    parameter int NO_SLAVES  = 3,
    parameter int DATA_WIDTH = 1,
    parameter int TIMEOUT    = 255,
    parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
    parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
) (
    input  logic                               clk,
    input  logic                               rstN,
    input  logic [M_ID_WIDTH+S_ID_WIDTH-1:0]   bus_state,
    input  logic                               state_vld,
    output logic                               state_ack,
    output logic                               busy,
    output logic                               done,
    output logic                               tout,
    output logic                               ready,
    input  logic [NO_MASTERS-1:0]              control_M,
    input  logic [NO_MASTERS-1:0]              valid_M,
    input  logic [NO_MASTERS-1:0]              last_M,
    input  logic [NO_MASTERS*DATA_WIDTH-1:0]   wD_M,
    output logic [NO_MASTERS*DATA_WIDTH-1:0]   rD_M,
    output logic [NO_MASTERS-1:0]              ready_M,
    output logic [NO_SLAVES-1:0]               control_S,
    output logic [NO_SLAVES-1:0]               valid_S,
    output logic [NO_SLAVES-1:0]               last_S,
    output logic [NO_SLAVES*DATA_WIDTH-1:0]    wD_S,
    input  logic [NO_SLAVES*DATA_WIDTH-1:0]    rD_S,
    input  logic [NO_SLAVES-1:0]               ready_S
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
    state_t state, state_nx;
    logic [M_ID_WIDTH-1:0] m_sel, req_m;
    logic [S_ID_WIDTH-1:0] s_sel, req_s;
    logic [15:0] wd_cnt;
    logic req_bad, req_park, fin, expire;
    logic m_ctrl, m_vld, m_last, s_rdy;
    logic [DATA_WIDTH-1:0] m_wd, s_rd;
    logic [NO_SLAVES-1:0] c_control_S, c_valid_S, c_last_S;
    logic [NO_SLAVES*DATA_WIDTH-1:0] c_wD_S;
    logic [NO_MASTERS*DATA_WIDTH-1:0] c_rD_M;
    logic [NO_MASTERS-1:0] c_ready_M;

    assign {req_m, req_s} = bus_state;
    assign req_bad = 32'(req_m) >= NO_MASTERS || 32'(req_s) > NO_SLAVES;
    assign req_park = 32'(req_s) == NO_SLAVES;
    assign fin = state == ACTIVE && m_vld && m_last && s_rdy;
    // an idle cycle cannot also be a last beat, so completion priority is implicit
    assign expire = state == ACTIVE && !m_vld && 32'(wd_cnt) == TIMEOUT - 1;

    always_ff @(posedge clk or negedge rstN)
        if (!rstN) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        if (state == IDLE && state_vld && !req_bad && !req_park) state_nx = ACTIVE;
        else if (fin || expire) state_nx = DRAIN;
        else if (state == DRAIN) state_nx = IDLE;
    end

    always_comb begin
        state_ack = state == IDLE && state_vld;
        busy = state != IDLE;
        ready = busy && s_rdy;
    end

    always_ff @(posedge clk or negedge rstN)
        if (!rstN) begin
            m_sel <= '0;
            s_sel <= '0;
            wd_cnt <= '0;
            tout <= 1'b0;
            done <= 1'b0;
        end else begin
            if (state == IDLE && state_nx == ACTIVE) begin
                m_sel <= req_m;
                s_sel <= req_s;
            end else if (state == DRAIN) begin
                m_sel <= '0;
                s_sel <= '0;
            end
            wd_cnt <= (state == ACTIVE && !m_vld) ? wd_cnt + 16'd1 : '0;
            tout <= (state_ack && req_bad) || expire;
            // tout is high throughout a timeout's DRAIN cycle, so it marks the abnormal path
            done <= state == DRAIN && !tout;
        end

    always_comb begin
        m_ctrl = 1'b0;
        m_vld = 1'b0;
        m_last = 1'b0;
        m_wd = '0;
        s_rdy = 1'b0;
        s_rd = '0;
        for (int i = 0; i < NO_MASTERS; i++)
            if (32'(m_sel) == i) begin
                m_ctrl = control_M[i];
                m_vld = valid_M[i];
                m_last = last_M[i];
                m_wd = wD_M[i*DATA_WIDTH +: DATA_WIDTH];
            end
        for (int i = 0; i < NO_SLAVES; i++)
            if (32'(s_sel) == i) begin
                s_rdy = ready_S[i];
                s_rd = rD_S[i*DATA_WIDTH +: DATA_WIDTH];
            end
    end

    always_comb begin
        c_control_S = '0;
        c_valid_S = '0;
        c_last_S = '0;
        c_wD_S = '0;
        c_rD_M = '0;
        c_ready_M = '1;
        for (int i = 0; i < NO_SLAVES; i++)
            if (busy && 32'(s_sel) == i) begin
                c_control_S[i] = m_ctrl;
                c_valid_S[i] = m_vld;
                c_last_S[i] = m_last;
                c_wD_S[i*DATA_WIDTH +: DATA_WIDTH] = m_wd;
            end
        for (int i = 0; i < NO_MASTERS; i++)
            if (busy && 32'(m_sel) == i) begin
                c_rD_M[i*DATA_WIDTH +: DATA_WIDTH] = s_rd;
                c_ready_M[i] = s_rdy;
            end
    end

`ifdef BUS_XBAR_PIPE_EN
    always_ff @(posedge clk or negedge rstN)
        if (!rstN) begin
            control_S <= '0;
            valid_S <= '0;
            last_S <= '0;
            wD_S <= '0;
            rD_M <= '0;
            ready_M <= '1;
        end else begin
            control_S <= c_control_S;
            valid_S <= c_valid_S;
            last_S <= c_last_S;
            wD_S <= c_wD_S;
            rD_M <= c_rD_M;
            ready_M <= c_ready_M;
        end
`else
    assign control_S = c_control_S;
    assign valid_S = c_valid_S;
    assign last_S = c_last_S;
    assign wD_S = c_wD_S;
    assign rD_M = c_rD_M;
    assign ready_M = c_ready_M;
`endif
endmodule

// File: tb/tb_bus_xbar_reg.sv
// tb_bus_xbar_reg: directed stimulus with a per-cycle transaction model plus literal spot checks.
module tb_bus_xbar_reg;
    localparam int NM = 3, NS = 3, DW = 4, TO = 4;
`ifdef BUS_XBAR_PIPE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    logic clk = 1'b0, rstN;
    logic [3:0] bus_state;
    logic state_vld, state_ack, busy, done, tout, ready;
    logic [NM-1:0] control_M, valid_M, last_M, ready_M;
    logic [NM*DW-1:0] wD_M, rD_M;
    logic [NS-1:0] control_S, valid_S, last_S, ready_S;
    logic [NS*DW-1:0] wD_S, rD_S;
    int nvec = 0, nerr = 0;

    bus_xbar_reg #(.NO_MASTERS(NM), .NO_SLAVES(NS), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstN(rstN), .bus_state(bus_state), .state_vld(state_vld),
        .state_ack(state_ack), .busy(busy), .done(done), .tout(tout), .ready(ready),
        .control_M(control_M), .valid_M(valid_M), .last_M(last_M), .wD_M(wD_M),
        .rD_M(rD_M), .ready_M(ready_M), .control_S(control_S), .valid_S(valid_S),
        .last_S(last_S), .wD_S(wD_S), .rD_S(rD_S), .ready_S(ready_S)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // transaction model: phase 0 idle, 1 connected, 2 drain
    initial begin
        int ph, cm, cs, idle_n, mid, sid;
        bit normal, p_done, p_tout, e_done, e_tout, conn;
        logic [NS-1:0] f_ctrl, f_vld, f_last, q_ctrl, q_vld, q_last;
        logic [NS*DW-1:0] f_wd, q_wd;
        logic [NM*DW-1:0] r_rd, q_rd;
        logic [NM-1:0] r_rdy, q_rdy;
        ph = 0; cm = 0; cs = 0; idle_n = 0; normal = 0; p_done = 0; p_tout = 0;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                ph = 0; p_done = 0; p_tout = 0;
                q_ctrl = '0; q_vld = '0; q_last = '0; q_wd = '0; q_rd = '0; q_rdy = '1;
                chk("rst_busy", busy, 0);
                chk("rst_ack", state_ack, 0);
                chk("rst_done", done, 0);
                chk("rst_tout", tout, 0);
                chk("rst_ready", ready, 0);
                chk("rst_slave", {control_S, valid_S, last_S, wD_S}, 0);
                chk("rst_rd", rD_M, 0);
                chk("rst_ready_m", ready_M, 3'b111);
            end else begin
                conn = ph != 0;
                f_ctrl = '0; f_vld = '0; f_last = '0; f_wd = '0; r_rd = '0; r_rdy = '1;
                if (conn) begin
                    f_ctrl[cs] = control_M[cm];
                    f_vld[cs] = valid_M[cm];
                    f_last[cs] = last_M[cm];
                    f_wd[cs*DW +: DW] = wD_M[cm*DW +: DW];
                    r_rd[cm*DW +: DW] = rD_S[cs*DW +: DW];
                    r_rdy[cm] = ready_S[cs];
                end
                chk("ack", state_ack, ph == 0 && state_vld);
                chk("busy", busy, conn);
                chk("ready", ready, conn && ready_S[cs]);
                chk("done", done, p_done);
                chk("tout", tout, p_tout);
                chk("control_S", control_S, LAT ? q_ctrl : f_ctrl);
                chk("valid_S", valid_S, LAT ? q_vld : f_vld);
                chk("last_S", last_S, LAT ? q_last : f_last);
                chk("wD_S", wD_S, LAT ? q_wd : f_wd);
                chk("rD_M", rD_M, LAT ? q_rd : r_rd);
                chk("ready_M", ready_M, LAT ? q_rdy : r_rdy);
                q_ctrl = f_ctrl; q_vld = f_vld; q_last = f_last; q_wd = f_wd; q_rd = r_rd; q_rdy = r_rdy;
                e_done = 0; e_tout = 0;
                if (ph == 0) begin
                    if (state_vld) begin
                        mid = int'(bus_state[3:2]);
                        sid = int'(bus_state[1:0]);
                        if (mid >= NM || sid > NS) e_tout = 1;
                        else if (sid != NS) begin ph = 1; cm = mid; cs = sid; idle_n = 0; end
                    end
                end else if (ph == 1) begin
                    if (valid_M[cm] && last_M[cm] && ready_S[cs]) begin ph = 2; normal = 1; end
                    else if (!valid_M[cm]) begin
                        idle_n++;
                        if (idle_n == TO) begin ph = 2; normal = 0; e_tout = 1; end
                    end else idle_n = 0;
                end else begin
                    ph = 0; cm = 0; cs = 0; e_done = normal;
                end
                p_done = e_done; p_tout = e_tout;
            end
        end
    end

    initial begin
        rstN = 0; bus_state = '0; state_vld = 0; control_M = '0; valid_M = '0; last_M = '0;
        wD_M = '0; ready_S = 3'b111; rD_S = 12'h521;
        tick(); #2;
        chk("lit_rst_busy", busy, 0);
        chk("lit_rst_ready_m", ready_M, 3'b111);
        chk("lit_rst_wd", wD_S, 0);
        tick(); rstN = 1;
        // M1 -> S2
        tick(); bus_state = 4'b0110; state_vld = 1; wD_M = 12'h0A0; #2;
        chk("lit_ack_12", state_ack, 1);
        tick(); state_vld = 0;
        repeat (LAT) tick();
        #2;
        chk("lit_wd_s2", wD_S, 12'hA00);
        chk("lit_rd_m1", rD_M, 12'h050);
        chk("lit_ready_s2", ready, 1);
        tick(); valid_M = 3'b010; wD_M = 12'h030;
        tick(); wD_M = 12'h0C0;
        tick(); wD_M = 12'h0F0;
        tick(); rstN = 0; #2;
        chk("lit_mid_rst_busy", busy, 0);
        chk("lit_mid_rst_slave", {valid_S, wD_S}, 0);
        chk("lit_mid_rst_ready_m", ready_M, 3'b111);
        valid_M = '0; wD_M = '0;
        tick(); tick(); rstN = 1;
        // M0 -> S1 normal close with back-to-back request
        tick(); bus_state = 4'b0001; state_vld = 1;
        tick(); state_vld = 0; valid_M = 3'b001; control_M = 3'b001; wD_M = 12'h005;
        tick(); last_M = 3'b001; wD_M = 12'h006;
        tick(); valid_M = '0; last_M = '0; control_M = '0; bus_state = 4'b1000; state_vld = 1; #2;
        chk("lit_drain_busy", busy, 1);
        chk("lit_drain_noack", state_ack, 0);
        tick(); #2;
        chk("lit_done_n2", done, 1);
        chk("lit_busy_n2", busy, 0);
        chk("lit_ack_n2", state_ack, 1);
        // M2 -> S0 slave stall
        tick(); state_vld = 0; ready_S = 3'b110; valid_M = 3'b100; last_M = 3'b100; wD_M = 12'h900; #2;
        chk("lit_stall_ready", ready, 0);
        tick(); #2;
        chk("lit_stall_busy", busy, 1);
        tick(); ready_S = 3'b111; #2;
        chk("lit_stall_rel", ready, 1);
        tick(); valid_M = '0; last_M = '0; #2;
        chk("lit_stall_drain", busy, 1);
        tick(); #2;
        chk("lit_stall_done", done, 1);
        // M0 -> S2 watchdog, restarted by a valid in cycle 3
        tick(); bus_state = 4'b0010; state_vld = 1;
        tick(); state_vld = 0;
        tick();
        tick(); valid_M = 3'b001;
        tick(); valid_M = '0;
        tick();
        tick();
        tick(); #2;
        chk("lit_wd_4th_idle", {busy, tout}, 2'b10);
        tick(); #2;
        chk("lit_wd_tout", {busy, tout}, 2'b11);
        tick(); #2;
        chk("lit_wd_after", {busy, tout, done}, 3'b000);
        // park then illegal master
        tick(); bus_state = 4'b0011; state_vld = 1; #2;
        chk("lit_park_ack", state_ack, 1);
        tick(); state_vld = 0; #2;
        chk("lit_park_idle", {busy, tout}, 2'b00);
        tick(); bus_state = 4'b1100; state_vld = 1; #2;
        chk("lit_bad_ack", state_ack, 1);
        tick(); state_vld = 0; #2;
        chk("lit_bad_tout", {busy, tout}, 2'b01);
        tick(); #2;
        chk("lit_bad_tout_end", tout, 0);
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
